// File: rtl/mem_stage_pkg.sv
// Shared MIPS memory-stage definitions: opcodes, exception codes, data-memory map.
// Also used by the instruction decoders and CP0.
package mem_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [31:0] DM_ADDR_LO = 32'h0000_0000;
    localparam logic [31:0] DM_ADDR_HI = 32'h0000_2FFF;
    localparam int          DM_WORDS   = 3072;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_W    = 3'd1,
        LD_H    = 3'd2,
        LD_HU   = 3'd3,
        LD_B    = 3'd4,
        LD_BU   = 3'd5
    } ld_type_e;

    // The map starts at address zero, so only the upper bound needs checking.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr <= DM_ADDR_HI);
    endfunction

endpackage

// File: rtl/mem_stage_dm_ext.sv
// Load-data extraction: selects the addressed byte/halfword and sign/zero-extends it.
module dm_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  ld_type_e    i_ltype,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lane selection and extension
    always_comb begin
        w_half = 16'h0;
        w_byte = 8'h0;
        o_data = i_word;
        if (i_addr_lo[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = 8'h0;
        endcase
        case (i_ltype)
            LD_W:    o_data = i_word;
            LD_H:    o_data = {{16{w_half[15]}}, w_half};
            LD_HU:   o_data = {16'h0, w_half};
            LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
            LD_BU:   o_data = {24'h0, w_byte};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: 3072-word data memory, combinational read, byte-enabled write, AdEL/AdES.
// Optional MEM_STAGE_TRACE_EN prints each committed write (simulation only).
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] I,
    input  logic [31:0] PC,
    input  logic [31:0] AO,
    input  logic [31:0] RT,
    input  logic        Flush,
    output logic [31:0] nWD,
    output logic [4:0]  ExcCode,
    output logic        ExcValid
);

    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_in_range;
    logic        w_exc;
    logic        w_we;
    ld_type_e    w_ltype;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rd_word;
    logic [31:0] w_new_word;
    logic [31:0] w_ld_data;
    logic [11:0] w_idx;
    logic [31:0] w_mem [DM_WORDS];

    assign w_idx      = AO[13:2];
    assign w_in_range = addr_in_range(AO);
    assign w_exc      = (w_is_load | w_is_store) & (w_misalign | ~w_in_range);
    assign w_we       = w_is_store & ~w_exc & ~Flush;
    assign w_rd_word  = w_in_range ? w_mem[w_idx] : 32'h0;
    assign ExcValid   = (ExcCode != EXC_NONE);

    // Opcode decode into access kind, alignment check and store lane enables
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_misalign = 1'b0;
        w_ltype    = LD_NONE;
        w_be       = 4'b0000;
        w_wdata    = RT;
        case (I[31:26])
            OP_LW:  begin w_is_load = 1'b1; w_ltype = LD_W;  w_misalign = (AO[1:0] != 2'b00); end
            OP_LH:  begin w_is_load = 1'b1; w_ltype = LD_H;  w_misalign = AO[0]; end
            OP_LHU: begin w_is_load = 1'b1; w_ltype = LD_HU; w_misalign = AO[0]; end
            OP_LB:  begin w_is_load = 1'b1; w_ltype = LD_B;  end
            OP_LBU: begin w_is_load = 1'b1; w_ltype = LD_BU; end
            OP_SW:  begin
                w_is_store = 1'b1;
                w_misalign = (AO[1:0] != 2'b00);
                w_be       = 4'b1111;
            end
            OP_SH:  begin
                w_is_store = 1'b1;
                w_misalign = AO[0];
                w_be       = AO[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{RT[15:0]}};
            end
            OP_SB:  begin
                w_is_store = 1'b1;
                w_be       = 4'b0001 << AO[1:0];
                w_wdata    = {4{RT[7:0]}};
            end
            default: begin
                w_is_load  = 1'b0;
                w_is_store = 1'b0;
            end
        endcase
    end

    // Merge store lanes into the current word
    always_comb begin
        w_new_word = w_rd_word;
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                w_new_word[8*b +: 8] = w_wdata[8*b +: 8];
            end else begin
                w_new_word[8*b +: 8] = w_rd_word[8*b +: 8];
            end
        end
    end

    dm_ext u_dm_ext (
        .i_word    (w_rd_word),
        .i_addr_lo (AO[1:0]),
        .i_ltype   (w_ltype),
        .o_data    (w_ld_data)
    );

    // Writeback data and exception code follow the inputs combinationally
    always_comb begin
        nWD     = AO;
        ExcCode = EXC_NONE;
        if (w_exc) begin
            ExcCode = w_is_load ? EXC_ADEL : EXC_ADES;
        end else begin
            ExcCode = EXC_NONE;
        end
        if (w_is_load) begin
            nWD = w_exc ? 32'h0 : w_ld_data;
        end else begin
            nWD = AO;
        end
    end

    // One register per word so the whole array clears asynchronously on reset
    for (genvar g = 0; g < DM_WORDS; g++) begin : g_word
        logic [31:0] r_word;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_word <= 32'h0;
            end else if (w_we && (w_idx == 12'(g))) begin
                r_word <= w_new_word;
            end
        end
        assign w_mem[g] = r_word;
    end

`ifdef MEM_STAGE_TRACE_EN
    // Simulation trace of committed writes
    always_ff @(posedge clk) begin
        if (w_we && !reset) begin
            $display("@%08h: *%08h <= %08h", PC, {AO[31:2], 2'b00}, w_new_word);
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{PC, I[25:0]};
`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL expose: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL expose: reset  input  1  asynchronous, active-high; clears the memory array.
REQ-003 SHALL expose: I  input  32  instruction held in the EX/MEM register.
REQ-004 SHALL expose: PC  input  32  PC of that instruction.
REQ-005 SHALL expose: AO  input  32  ALU result; effective address for loads and stores.
REQ-006 SHALL expose: RT  input  32  forwarded rt value, used as store data.
REQ-007 SHALL expose: Flush  input  1  exception commit from CP0; suppresses the store this cycle.
REQ-008 SHALL expose: nWD  output  32  writeback data for the MEM/WB register.
REQ-009 SHALL expose: ExcCode  output  5  0 = none, 4 = AdEL, 5 = AdES.
REQ-010 SHALL expose: ExcValid  output  1  high when ExcCode is non-zero.

Function
REQ-011 SHALL decode lb/lbu/lh/lhu/lw/sb/sh/sw from I.
- Opcode: I[31:26].
- All other instructions are non-memory.
REQ-012 SHALL hold a 3072 x 32-bit data array.
- Mapped range: byte addresses 0x0000_0000 to 0x0000_2FFF.
- Word index: AO[13:2].
REQ-013 SHALL read combinationally, so nWD is valid in the same cycle as the inputs (zero-cycle latency).
REQ-014 SHALL write on the rising clk edge only when all hold: store decoded, ExcValid=0, Flush=0.
REQ-015 SHALL generate store byte enables:
- sw: all four bytes.
- sh: bytes {AO[1],0} and {AO[1],1}, taking RT[15:0].
- sb: byte AO[1:0], taking RT[7:0].
- Unselected bytes keep their old value.
REQ-016 SHALL extract load data:
- lw: whole word.
- lh/lhu: halfword AO[1]; sign- or zero-extended to 32 bits.
- lb/lbu: byte AO[1:0]; sign- or zero-extended to 32 bits.
REQ-017 SHALL drive nWD:
- Load: the extended load data.
- Any other instruction: AO.
REQ-018 SHALL raise AdEL (code 4) for a load, or AdES (code 5) for a store, when:
- lw/sw has AO[1:0] != 0; or
- lh/lhu/sh has AO[0] = 1; or
- AO is outside the mapped range.
REQ-019 SHALL make an exception take effect in the same cycle:
- The faulting store is not written.
- nWD for a faulting load is 0.
REQ-020 SHALL treat a load and a store to the same word in consecutive cycles as ordinary: the load sees the value written at the preceding edge.
REQ-021 SHALL keep ExcCode=0 and leave memory untouched when I=0 (bubble).

Reset
REQ-022 SHALL clear every memory word to 0 immediately when reset rises, independent of clk.
REQ-023 SHALL block writes while reset is high, including a store that coincides with a clk edge.
REQ-024 SHALL keep nWD and ExcCode purely combinational, so they follow the current inputs during reset.

Configuration
REQ-025 SHALL support macro MEM_STAGE_TRACE_EN.
- Defined: every committed write prints one simulation-only line "@<PC>: *<word-aligned addr> <= <new full word>" in 8-digit hex.
- Undefined: no trace code is compiled and behaviour is otherwise identical.

Structure
REQ-026 SHALL place in a shared package (also used by the decoders and CP0):
- Opcode constants.
- Exception-code constants (AdEL=4, AdES=5).
- Address-map bounds.
REQ-027 SHALL put load extraction/extension in one sub-module, dm_ext:
- Inputs: word, AO[1:0], load type.
- Output: 32-bit extended data.

Verification
REQ-028 SHALL cover word round-trip:
- Stimulus: sw RT=0x12345678 at AO=0x100; next cycle lw at AO=0x100.
- Required: nWD=0x12345678; ExcCode=0.
REQ-029 SHALL cover sub-word stores and loads:
- Stimulus: word 0x100 = 0x12345678; sb RT=0xAB at 0x103; then lb 0x103, lbu 0x103, lh 0x102.
- Required: stored word 0xAB345678; nWD = 0xFFFFFFAB, then 0x000000AB, then 0xFFFFAB34.
REQ-030 SHALL cover misaligned access:
- Stimulus: sw at AO=0x102.
- Required: ExcCode=5; memory unchanged.
- Stimulus: lh at AO=0x101.
- Required: ExcCode=4; nWD=0.
REQ-031 SHALL cover out-of-range access:
- Stimulus: lw at AO=0x3000.
- Required: ExcCode=4.
- Stimulus: sw at AO=0xFFFFFFFC.
- Required: ExcCode=5; no write.
REQ-032 SHALL cover flush:
- Stimulus: sw RT=0xDEADBEEF at 0x200 with Flush=1.
- Required: a later lw at 0x200 returns the prior value 0.
REQ-033 SHALL cover asynchronous reset:
- Stimulus: write 0x55 to 0x0; pulse reset between clk edges.
- Required: an immediate lw at 0x0 returns 0; a store coinciding with reset is dropped.
